// File: rtl/hybridift_axi_master128.sv
// hybridift_axi_master128: single-outstanding mem_req to AXI4 single-beat 128-bit master bridge; ports: pll_core_cpuclk/pad_cpu_rst, mem_* request/response, AXI m0 AR/R/AW/W/B channels, timeout_o when HYBRIDIFT_AXI_MST_TIMEOUT_EN is defined
module hybridift_axi_master128 #(
    parameter logic [7:0] AXI_ID = 8'h00
) (
    input  logic         pll_core_cpuclk,
    input  logic         pad_cpu_rst,
    input  logic         mem_req_i,
    output logic         mem_gnt_o,
    input  logic [39:0]  mem_addr_i,
    input  logic         mem_we_i,
    input  logic [127:0] mem_wdata_i,
    input  logic [15:0]  mem_strb_i,
    output logic         mem_rsp_valid_o,
    output logic [127:0] mem_rdata_o,
    output logic         mem_err_o,
    output logic [39:0]  araddr_m0,
    output logic [1:0]   arburst_m0,
    output logic [3:0]   arcache_m0,
    output logic [7:0]   arid_m0,
    output logic [7:0]   arlen_m0,
    output logic [2:0]   arprot_m0,
    output logic [2:0]   arsize_m0,
    output logic         arvalid_m0,
    input  logic         arready_m0,
    output logic [39:0]  awaddr_m0,
    output logic [1:0]   awburst_m0,
    output logic [3:0]   awcache_m0,
    output logic [7:0]   awid_m0,
    output logic [7:0]   awlen_m0,
    output logic [2:0]   awprot_m0,
    output logic [2:0]   awsize_m0,
    output logic         awvalid_m0,
    input  logic         awready_m0,
    output logic [127:0] wdata_m0,
    output logic [15:0]  wstrb_m0,
    output logic [7:0]   wid_m0,
    output logic         wlast_m0,
    output logic         wvalid_m0,
    input  logic         wready_m0,
    input  logic [127:0] rdata_m0,
    input  logic [7:0]   rid_m0,
    input  logic         rlast_m0,
    input  logic [1:0]   rresp_m0,
    input  logic         rvalid_m0,
    output logic         rready_m0,
    input  logic [7:0]   bid_m0,
    input  logic [1:0]   bresp_m0,
    input  logic         bvalid_m0,
    output logic         bready_m0
`ifdef HYBRIDIFT_AXI_MST_TIMEOUT_EN
    ,
    output logic         timeout_o
`endif
);
    typedef enum logic [2:0] {IDLE, AR, R, AWW, B} state_t;
    state_t state, state_n;
    logic [35:0]  addr_q;
    logic         we_q;
    logic [127:0] wdata_q;
    logic [15:0]  strb_q;
    logic         aw_done, w_done, aw_fin, w_fin, rsp_hs;
    logic         rsp_valid_q, err_q;
    logic [127:0] rdata_q;
    logic         unused;
    assign unused = ^{rid_m0, bid_m0, mem_addr_i[3:0]};
    assign mem_gnt_o = state == IDLE && mem_req_i && !rsp_valid_q;
    assign arvalid_m0 = state == AR;
    assign rready_m0 = state == R;
    assign awvalid_m0 = state == AWW && !aw_done;
    assign wvalid_m0 = state == AWW && !w_done;
    assign bready_m0 = state == B;
    assign wlast_m0 = wvalid_m0;
    assign araddr_m0 = {addr_q, 4'h0};
    assign awaddr_m0 = {addr_q, 4'h0};
    assign arburst_m0 = 2'b01;
    assign awburst_m0 = 2'b01;
    assign arcache_m0 = 4'b0000;
    assign awcache_m0 = 4'b0000;
    assign arprot_m0 = 3'b000;
    assign awprot_m0 = 3'b000;
    assign arsize_m0 = 3'b100;
    assign awsize_m0 = 3'b100;
    assign arlen_m0 = 8'h00;
    assign awlen_m0 = 8'h00;
    assign arid_m0 = AXI_ID;
    assign awid_m0 = AXI_ID;
    assign wid_m0 = AXI_ID;
    assign wdata_m0 = wdata_q;
    assign wstrb_m0 = strb_q;
    assign aw_fin = aw_done || (awvalid_m0 && awready_m0);
    assign w_fin = w_done || (wvalid_m0 && wready_m0);
    assign rsp_hs = we_q ? (state == B && bvalid_m0) : (state == R && rvalid_m0 && rlast_m0);
    assign mem_rsp_valid_o = rsp_valid_q;
    assign mem_rdata_o = rdata_q;
    assign mem_err_o = err_q;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = mem_gnt_o ? (mem_we_i ? AWW : AR) : IDLE;
            AR:      state_n = arready_m0 ? R : AR;
            R:       state_n = (rvalid_m0 && rlast_m0) ? IDLE : R;
            AWW:     state_n = (aw_fin && w_fin) ? B : AWW;
            B:       state_n = bvalid_m0 ? IDLE : B;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            state <= IDLE;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            aw_done <= state == AWW && state_n == AWW && aw_fin;
            w_done <= state == AWW && state_n == AWW && w_fin;
            rsp_valid_q <= rsp_hs;
            if (rsp_hs) begin
                rdata_q <= we_q ? '0 : rdata_m0;
                err_q <= (we_q ? bresp_m0 : rresp_m0) != 2'b00;
            end
        end
    end
    always_ff @(posedge pll_core_cpuclk) begin
        if (mem_gnt_o) begin
            addr_q <= mem_addr_i[39:4];
            we_q <= mem_we_i;
            wdata_q <= mem_wdata_i;
            strb_q <= mem_strb_i;
        end
    end
`ifdef HYBRIDIFT_AXI_MST_TIMEOUT_EN
    logic [9:0] wait_cnt;
    logic       timeout_q, in_wait;
    assign in_wait = state == R || state == B;
    assign timeout_o = timeout_q;
    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            wait_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= in_wait ? wait_cnt + {9'd0, wait_cnt != 10'h3ff} : '0;
            timeout_q <= timeout_q || (in_wait && wait_cnt == 10'd1022);
        end
    end
`endif
endmodule

// File: tb/tb_hybridift_axi_master128.sv
// tb_hybridift_axi_master128: self-checking bench for hybridift_axi_master128 with directed table, random transactions and corner sequences
module tb_hybridift_axi_master128;
    localparam logic [7:0] ID = 8'h5A;
    logic         pll_core_cpuclk = 1'b0;
    logic         pad_cpu_rst = 1'b1;
    logic         mem_req_i = 1'b0, mem_we_i = 1'b0;
    logic         mem_gnt_o, mem_rsp_valid_o, mem_err_o;
    logic [39:0]  mem_addr_i = '0;
    logic [127:0] mem_wdata_i = '0, mem_rdata_o;
    logic [15:0]  mem_strb_i = '0;
    logic [39:0]  araddr_m0, awaddr_m0;
    logic [1:0]   arburst_m0, awburst_m0;
    logic [3:0]   arcache_m0, awcache_m0;
    logic [7:0]   arid_m0, arlen_m0, awid_m0, awlen_m0, wid_m0;
    logic [2:0]   arprot_m0, arsize_m0, awprot_m0, awsize_m0;
    logic         arvalid_m0, awvalid_m0, wvalid_m0, wlast_m0, rready_m0, bready_m0;
    logic         arready_m0 = 1'b0, awready_m0 = 1'b0, wready_m0 = 1'b0;
    logic [127:0] wdata_m0;
    logic [15:0]  wstrb_m0;
    logic [127:0] rdata_m0 = '0;
    logic [7:0]   rid_m0 = '0, bid_m0 = '0;
    logic         rlast_m0 = 1'b0, rvalid_m0 = 1'b0, bvalid_m0 = 1'b0;
    logic [1:0]   rresp_m0 = '0, bresp_m0 = '0;
`ifdef HYBRIDIFT_AXI_MST_TIMEOUT_EN
    logic         timeout_o;
`endif
    int pass_cnt = 0, total_cnt = 0;

    hybridift_axi_master128 #(.AXI_ID(ID)) dut (
        .pll_core_cpuclk(pll_core_cpuclk), .pad_cpu_rst(pad_cpu_rst),
        .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
        .mem_rsp_valid_o(mem_rsp_valid_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .araddr_m0(araddr_m0), .arburst_m0(arburst_m0), .arcache_m0(arcache_m0), .arid_m0(arid_m0),
        .arlen_m0(arlen_m0), .arprot_m0(arprot_m0), .arsize_m0(arsize_m0), .arvalid_m0(arvalid_m0),
        .arready_m0(arready_m0),
        .awaddr_m0(awaddr_m0), .awburst_m0(awburst_m0), .awcache_m0(awcache_m0), .awid_m0(awid_m0),
        .awlen_m0(awlen_m0), .awprot_m0(awprot_m0), .awsize_m0(awsize_m0), .awvalid_m0(awvalid_m0),
        .awready_m0(awready_m0),
        .wdata_m0(wdata_m0), .wstrb_m0(wstrb_m0), .wid_m0(wid_m0), .wlast_m0(wlast_m0),
        .wvalid_m0(wvalid_m0), .wready_m0(wready_m0),
        .rdata_m0(rdata_m0), .rid_m0(rid_m0), .rlast_m0(rlast_m0), .rresp_m0(rresp_m0),
        .rvalid_m0(rvalid_m0), .rready_m0(rready_m0),
        .bid_m0(bid_m0), .bresp_m0(bresp_m0), .bvalid_m0(bvalid_m0), .bready_m0(bready_m0)
`ifdef HYBRIDIFT_AXI_MST_TIMEOUT_EN
        , .timeout_o(timeout_o)
`endif
    );

    always #5 pll_core_cpuclk = ~pll_core_cpuclk;

    typedef struct {
        bit           we;
        logic [39:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  strb;
        logic [127:0] rdata;
        logic [1:0]   resp;
        int           a_dly;
        int           w_dly;
        int           s_dly;
        logic [39:0]  exp_addr;
        logic [127:0] exp_rdata;
        bit           exp_err;
    } txn_t;

    txn_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic cyc();
        @(posedge pll_core_cpuclk);
        @(negedge pll_core_cpuclk);
    endtask

    function automatic txn_t model(input txn_t t);
        txn_t m = t;
        m.exp_addr = t.addr - (t.addr % 40'd16);
        m.exp_rdata = t.we ? 128'd0 : t.rdata;
        m.exp_err = t.resp != 2'b00;
        return m;
    endfunction

    task automatic run_txn(input txn_t t);
        int last;
        @(negedge pll_core_cpuclk);
        mem_req_i = 1'b1;
        mem_we_i = t.we;
        mem_addr_i = t.addr;
        mem_wdata_i = t.wdata;
        mem_strb_i = t.strb;
        #1 chk("gnt", mem_gnt_o, 1'b1);
        cyc();
        mem_req_i = 1'b0;
        mem_wdata_i = ~t.wdata;
        if (!t.we) begin
            for (int c = 0; c <= t.a_dly; c++) begin
                arready_m0 = c == t.a_dly;
                rvalid_m0 = 1'b1;
                rlast_m0 = 1'b1;
                rdata_m0 = ~t.rdata;
                rresp_m0 = 2'b11;
                #1;
                chk("arvalid", arvalid_m0, 1'b1);
                chk("araddr", araddr_m0, t.exp_addr);
                chk("ar_attr", {arlen_m0, arsize_m0, arburst_m0, arcache_m0, arprot_m0, arid_m0},
                    {8'h00, 3'b100, 2'b01, 4'b0000, 3'b000, ID});
                chk("rready_in_ar", rready_m0, 1'b0);
                cyc();
            end
            arready_m0 = 1'b0;
            rvalid_m0 = 1'b0;
            rlast_m0 = 1'b0;
            for (int c = 0; c < t.s_dly; c++) begin
                #1;
                chk("r_wait", {rready_m0, arvalid_m0, mem_rsp_valid_o}, 3'b100);
                cyc();
            end
            rvalid_m0 = 1'b1;
            rlast_m0 = 1'b1;
            rdata_m0 = t.rdata;
            rresp_m0 = t.resp;
            rid_m0 = 8'($urandom);
            #1 chk("rready", rready_m0, 1'b1);
            cyc();
            rvalid_m0 = 1'b0;
            rlast_m0 = 1'b0;
        end else begin
            last = t.a_dly > t.w_dly ? t.a_dly : t.w_dly;
            for (int c = 0; c <= last; c++) begin
                awready_m0 = c == t.a_dly;
                wready_m0 = c == t.w_dly;
                bvalid_m0 = 1'b1;
                bresp_m0 = 2'b11;
                #1;
                chk("awvalid", awvalid_m0, c <= t.a_dly);
                chk("wvalid", wvalid_m0, c <= t.w_dly);
                chk("awaddr", awaddr_m0, t.exp_addr);
                chk("aw_attr", {awlen_m0, awsize_m0, awburst_m0, awcache_m0, awprot_m0, awid_m0},
                    {8'h00, 3'b100, 2'b01, 4'b0000, 3'b000, ID});
                chk("bready_in_aww", bready_m0, 1'b0);
                if (c <= t.w_dly) chk("w_beat", {wlast_m0, wid_m0, wstrb_m0, wdata_m0}, {1'b1, ID, t.strb, t.wdata});
                cyc();
            end
            awready_m0 = 1'b0;
            wready_m0 = 1'b0;
            bvalid_m0 = 1'b0;
            for (int c = 0; c < t.s_dly; c++) begin
                #1;
                chk("b_wait", {bready_m0, awvalid_m0, wvalid_m0, mem_rsp_valid_o}, 4'b1000);
                cyc();
            end
            bvalid_m0 = 1'b1;
            bresp_m0 = t.resp;
            bid_m0 = 8'($urandom);
            #1 chk("bready", bready_m0, 1'b1);
            cyc();
            bvalid_m0 = 1'b0;
        end
        #1;
        chk("rsp_pulse", mem_rsp_valid_o, 1'b1);
        chk("rsp_rdata", mem_rdata_o, t.exp_rdata);
        chk("rsp_err", mem_err_o, t.exp_err);
        cyc();
        #1;
        chk("rsp_single", mem_rsp_valid_o, 1'b0);
        chk("rdata_hold", mem_rdata_o, t.exp_rdata);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        tbl.push_back('{we:0, addr:40'h1234, wdata:'0, strb:'0, rdata:{16{8'hA5}}, resp:2'b00,
                        a_dly:0, w_dly:0, s_dly:0, exp_addr:40'h1230, exp_rdata:{16{8'hA5}}, exp_err:0});
        tbl.push_back('{we:1, addr:40'hFF_0000_001F, wdata:{4{32'hDEAD_BEEF}}, strb:16'hF0F0, rdata:'0, resp:2'b10,
                        a_dly:3, w_dly:0, s_dly:1, exp_addr:40'hFF_0000_0010, exp_rdata:'0, exp_err:1});
        tbl.push_back('{we:1, addr:40'h00_0000_0040, wdata:{2{64'h0123_4567_89AB_CDEF}}, strb:16'hFFFF, rdata:'0, resp:2'b00,
                        a_dly:0, w_dly:0, s_dly:0, exp_addr:40'h00_0000_0040, exp_rdata:'0, exp_err:0});
        tbl.push_back('{we:1, addr:40'h12_3456_7899, wdata:{8{16'h5A5A}}, strb:16'h0001, rdata:'0, resp:2'b11,
                        a_dly:0, w_dly:2, s_dly:2, exp_addr:40'h12_3456_7890, exp_rdata:'0, exp_err:1});
        tbl.push_back('{we:0, addr:40'hAB_CDEF_000F, wdata:'0, strb:'0, rdata:{8{16'h1234}}, resp:2'b01,
                        a_dly:2, w_dly:0, s_dly:3, exp_addr:40'hAB_CDEF_0000, exp_rdata:{8{16'h1234}}, exp_err:1});
        for (int i = 0; i < 30; i++) begin
            t.we = 1'($urandom_range(0, 1));
            t.addr = {8'($urandom), 32'($urandom)};
            t.wdata = {$urandom, $urandom, $urandom, $urandom};
            t.strb = 16'($urandom);
            t.rdata = {$urandom, $urandom, $urandom, $urandom};
            t.resp = 2'($urandom_range(0, 3));
            t.a_dly = $urandom_range(0, 3);
            t.w_dly = $urandom_range(0, 3);
            t.s_dly = $urandom_range(0, 3);
            tbl.push_back(model(t));
        end

        repeat (3) @(negedge pll_core_cpuclk);
        #1;
        chk("rst_valids", {arvalid_m0, awvalid_m0, wvalid_m0, rready_m0, bready_m0}, 5'b0);
        chk("rst_rsp", {mem_rsp_valid_o, mem_err_o}, 2'b0);
        chk("rst_rdata", mem_rdata_o, 128'd0);
        pad_cpu_rst = 1'b0;
        cyc();
        #1 chk("post_rst_idle", {arvalid_m0, awvalid_m0, wvalid_m0, rready_m0, bready_m0, mem_rsp_valid_o}, 6'b0);

        foreach (tbl[i]) run_txn(tbl[i]);

        @(negedge pll_core_cpuclk);
        mem_req_i = 1'b1;
        mem_we_i = 1'b0;
        mem_addr_i = 40'h80;
        #1 chk("b2b_gnt1", mem_gnt_o, 1'b1);
        cyc();
        arready_m0 = 1'b1;
        #1 chk("b2b_gnt_ar", mem_gnt_o, 1'b0);
        cyc();
        arready_m0 = 1'b0;
        rvalid_m0 = 1'b1;
        rlast_m0 = 1'b1;
        rdata_m0 = 128'h77;
        rresp_m0 = 2'b00;
        #1 chk("b2b_gnt_r", mem_gnt_o, 1'b0);
        cyc();
        rvalid_m0 = 1'b0;
        rlast_m0 = 1'b0;
        #1;
        chk("b2b_rsp1", mem_rsp_valid_o, 1'b1);
        chk("b2b_gnt_pulse", mem_gnt_o, 1'b0);
        cyc();
        #1;
        chk("b2b_rsp1_end", mem_rsp_valid_o, 1'b0);
        chk("b2b_gnt2", mem_gnt_o, 1'b1);
        cyc();
        mem_req_i = 1'b0;
        #1 chk("b2b_arvalid2", arvalid_m0, 1'b1);
        arready_m0 = 1'b1;
        cyc();
        arready_m0 = 1'b0;
        rvalid_m0 = 1'b1;
        rlast_m0 = 1'b1;
        rdata_m0 = 128'h88;
        cyc();
        rvalid_m0 = 1'b0;
        rlast_m0 = 1'b0;
        #1 chk("b2b_rsp2", {mem_rsp_valid_o, mem_rdata_o}, {1'b1, 128'h88});

        cyc();
        mem_req_i = 1'b1;
        mem_addr_i = 40'h100;
        cyc();
        mem_req_i = 1'b0;
        arready_m0 = 1'b1;
        cyc();
        arready_m0 = 1'b0;
        #1 chk("rst_mid_rready", rready_m0, 1'b1);
        rvalid_m0 = 1'b1;
        rlast_m0 = 1'b1;
        rdata_m0 = 128'hBAD;
        pad_cpu_rst = 1'b1;
        cyc();
        #1 chk("rst_mid_outs", {rready_m0, arvalid_m0, mem_rsp_valid_o}, 3'b000);
        cyc();
        pad_cpu_rst = 1'b0;
        #1 chk("rst_mid_norsp", mem_rsp_valid_o, 1'b0);
        cyc();
        rvalid_m0 = 1'b0;
        rlast_m0 = 1'b0;
        #1;
        chk("rst_mid_after", {rready_m0, mem_rsp_valid_o, mem_err_o}, 3'b000);
        chk("rst_mid_rdata", mem_rdata_o, 128'd0);
        run_txn(tbl[1]);
        run_txn(tbl[0]);

`ifdef HYBRIDIFT_AXI_MST_TIMEOUT_EN
        @(negedge pll_core_cpuclk);
        mem_req_i = 1'b1;
        mem_we_i = 1'b1;
        cyc();
        mem_req_i = 1'b0;
        awready_m0 = 1'b1;
        wready_m0 = 1'b1;
        cyc();
        awready_m0 = 1'b0;
        wready_m0 = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            #1;
            if (k == 0) chk("to_start", timeout_o, 1'b0);
            if (k == 1022) chk("to_before", timeout_o, 1'b0);
            if (k == 1023) chk("to_set", timeout_o, 1'b1);
            if (k == 1099) chk("to_waiting", {timeout_o, bready_m0}, 2'b11);
            cyc();
        end
        bvalid_m0 = 1'b1;
        bresp_m0 = 2'b00;
        cyc();
        bvalid_m0 = 1'b0;
        #1 chk("to_rsp", {mem_rsp_valid_o, mem_err_o, timeout_o}, 3'b101);
        cyc();
        #1 chk("to_sticky", timeout_o, 1'b1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
